// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state codes, line constants and divisor clamp.
package uart_pkg;
  typedef enum logic [3:0] {
    IDLE  = 4'h0,
    START = 4'h1,
    DATA  = 4'h2,
    STOP  = 4'h3
  } tx_state_e;
  localparam logic IDLE_LVL = 1'b1;
  localparam int FRAME_W = 8;
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return d == 16'd0 ? 16'd1 : d;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable bit-period down-counter with end-of-bit flags.
module uart_baud_cnt
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] div_i,
  output logic        bit_end_o,
  output logic        next_end_o
);
  logic [15:0] cnt_q, cnt_d, top;
  assign top = clamp_div(div_i) - 16'd1;
  assign bit_end_o = cnt_q == 16'd0;
  always_comb cnt_d = (load_i || (en_i && bit_end_o)) ? top : en_i ? cnt_q - 16'd1 : cnt_q;
  // lets the owner register a pulse that lands on the last cycle of the next bit
  assign next_end_o = cnt_d == 16'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: pops 16-bit FIFO words and sends each as two 8N1 UART frames.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int STOP_BITS = 1,
  parameter bit HI_FIRST  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] tx_fifo_data,
  input  logic        tx_fifo_empty,
  output logic        tx_fifo_rd,
  input  logic [15:0] baud,
  output logic        txd,
  output logic [3:0]  state,
  output logic        tx_done
);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_W - 1);
  tx_state_e   state_q;
  logic        txd_q, rd_q, done_q, byte_q, bit_end, next_end;
  logic [2:0]  idx_q;
  logic [15:0] word_q, div_q;
  logic [7:0]  cur;
  assign cur = (byte_q ^ HI_FIRST) ? word_q[15:8] : word_q[7:0];
  uart_baud_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == IDLE && rd_q),
    .en_i       (state_q != IDLE),
    .div_i      (div_q),
    .bit_end_o  (bit_end),
    .next_end_o (next_end)
  );
  // tx_done is registered one cycle early so it coincides with the final stop cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      txd_q   <= IDLE_LVL;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      byte_q  <= 1'b0;
      idx_q   <= '0;
      word_q  <= '0;
      div_q   <= '0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE:
          if (rd_q) begin
            state_q <= START;
            txd_q   <= 1'b0;
            byte_q  <= 1'b0;
            idx_q   <= '0;
          end else if (!tx_fifo_empty) begin
            rd_q   <= 1'b1;
            word_q <= tx_fifo_data;
            div_q  <= baud;
          end
        START:
          if (bit_end) begin
            state_q <= DATA;
            txd_q   <= cur[0];
          end
        DATA:
          if (bit_end && idx_q == LAST_BIT) begin
            state_q <= STOP;
            idx_q   <= '0;
            txd_q   <= IDLE_LVL;
            done_q  <= byte_q && LAST_STOP == 3'd0 && next_end;
          end else if (bit_end) begin
            idx_q <= idx_q + 3'd1;
            txd_q <= cur[idx_q + 3'd1];
          end
        STOP:
          if (!bit_end) done_q <= byte_q && idx_q == LAST_STOP && next_end;
          else if (idx_q != LAST_STOP) begin
            idx_q  <= idx_q + 3'd1;
            done_q <= byte_q && idx_q + 3'd1 == LAST_STOP && next_end;
          end else if (!byte_q) begin
            state_q <= START;
            txd_q   <= 1'b0;
            byte_q  <= 1'b1;
            idx_q   <= '0;
          end else begin
            state_q <= IDLE;
            idx_q   <= '0;
          end
        default: begin
          state_q <= IDLE;
          txd_q   <= IDLE_LVL;
        end
      endcase
    end
  assign txd        = txd_q;
  assign tx_fifo_rd = rd_q;
  assign tx_done    = done_q;
  assign state      = state_q;
endmodule
